// File: rtl/sobel_pass_scheduler_if.sv
// Read/write bus between the pass scheduler, the source/output BRAMs and the shared Sobel core.
interface sobel_pass_scheduler_if #(
    parameter int ADDR_W = 16
);
    logic              hold;
    logic              res_valid;
    logic              ena_input;
    logic [ADDR_W-1:0] addra_input;
    logic              px_valid;
    logic              ena_output;
    logic              wea_output;
    logic [ADDR_W-1:0] addra_output;
    logic              ena_output_bb;
    logic              wea_output_bb;
    logic [ADDR_W-1:0] addra_output_bb;

    modport master (
        input  hold, res_valid,
        output ena_input, addra_input, px_valid,
        output ena_output, wea_output, addra_output,
        output ena_output_bb, wea_output_bb, addra_output_bb
    );

    modport slave (
        output hold, res_valid,
        input  ena_input, addra_input, px_valid,
        input  ena_output, wea_output, addra_output,
        input  ena_output_bb, wea_output_bb, addra_output_bb
    );
endinterface

// File: rtl/sobel_pass_scheduler.sv
// Two-pass Sobel sequencer: full background frame, then the bbox window, each with its own
// threshold and output BRAM; done once both passes have drained their results.
module sobel_pass_scheduler #(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int BB_W    = 192,
    parameter int BB_H    = 251,
    parameter int BBOX_X0 = 0,
    parameter int BBOX_Y0 = 2,
    parameter int ADDR_W  = 16
) (
    input  logic       clka,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] error_bck,
    input  logic [5:0] error_bb,
    output logic       pass_sel,
    output logic [5:0] err_sel,
    output logic       busy,
    output logic       done,
    output logic       proto_err,
    sobel_pass_scheduler_if.master bus
);
    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    // One extra bit so a full 2^ADDR_W frame count is representable.
    localparam int WW       = ADDR_W + 1;
    localparam int NPIX_BCK = IMG_W * IMG_H;
    localparam int NPIX_BB  = BB_W * BB_H;

    if (BBOX_X0 + BB_W > IMG_W || BBOX_Y0 + BB_H > IMG_H) begin : g_bad_bbox
        $error("sobel_pass_scheduler: bbox window exceeds the source frame");
    end

    typedef enum logic [2:0] {IDLE, PASS_BCK, DRAIN_BCK, PASS_BB, DRAIN_BB, DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [WW-1:0]     wcnt;
    logic [WW-1:0]     npix;
    logic [ADDR_W-1:0] rd_addr;
    logic              bb_phase, in_pass, issue, accept, perr_set;
    logic              last_col, last_row, w_full, pass_entry;

    always_ff @(posedge clka) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx           = state;
        bb_phase           = (state == PASS_BB) || (state == DRAIN_BB);
        in_pass            = (state == PASS_BCK) || (state == DRAIN_BCK) || bb_phase;
        npix               = bb_phase ? WW'(NPIX_BB) : WW'(NPIX_BCK);
        issue              = ((state == PASS_BCK) || (state == PASS_BB)) && !bus.hold;
        last_col           = (state == PASS_BB) ? (col == CW'(BB_W - 1)) : (col == CW'(IMG_W - 1));
        last_row           = (state == PASS_BB) ? (row == RW'(BB_H - 1)) : (row == RW'(IMG_H - 1));
        accept             = bus.res_valid && in_pass && (wcnt < npix);
        perr_set           = bus.res_valid && !accept;
        // Drain ends on the edge that lands the final write, so done follows it by one cycle.
        w_full             = accept ? (wcnt == npix - WW'(1)) : (wcnt == npix);
        bus.ena_output     = accept && !bb_phase;
        bus.wea_output     = accept && !bb_phase;
        bus.ena_output_bb  = accept && bb_phase;
        bus.wea_output_bb  = accept && bb_phase;
        bus.addra_output    = wcnt[ADDR_W-1:0];
        bus.addra_output_bb = wcnt[ADDR_W-1:0];
        busy               = in_pass;
        done               = (state == DONE);
        case (state)
            IDLE, DONE: if (start)                 state_nx = PASS_BCK;
            PASS_BCK:   if (issue && last_col && last_row) state_nx = DRAIN_BCK;
            DRAIN_BCK:  if (w_full)                state_nx = PASS_BB;
            PASS_BB:    if (issue && last_col && last_row) state_nx = DRAIN_BB;
            DRAIN_BB:   if (w_full)                state_nx = DONE;
            default:                               state_nx = IDLE;
        endcase
        pass_entry = (state_nx != state) && ((state_nx == PASS_BCK) || (state_nx == PASS_BB));
    end

    always_comb begin
        if (state == PASS_BB)
            rd_addr = (ADDR_W'(row) + ADDR_W'(BBOX_Y0)) * ADDR_W'(IMG_W)
                    + ADDR_W'(col) + ADDR_W'(BBOX_X0);
        else
            rd_addr = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    end

    always_ff @(posedge clka) begin
        if (!reset) begin
            col             <= '0;
            row             <= '0;
            wcnt            <= '0;
            bus.ena_input   <= 1'b0;
            bus.addra_input <= '0;
            bus.px_valid    <= 1'b0;
            pass_sel        <= 1'b0;
            err_sel         <= '0;
            proto_err       <= 1'b0;
        end else begin
            bus.ena_input <= issue;
            bus.px_valid  <= bus.ena_input;
            if (issue) bus.addra_input <= rd_addr;
            if (pass_entry) begin
                col      <= '0;
                row      <= '0;
                wcnt     <= '0;
                pass_sel <= (state_nx == PASS_BB);
                err_sel  <= (state_nx == PASS_BB) ? error_bb : error_bck;
            end else begin
                if (issue) begin
                    if (last_col) begin
                        col <= '0;
                        row <= last_row ? '0 : row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                if (accept) wcnt <= wcnt + WW'(1);
            end
            if (perr_set) proto_err <= 1'b1;
        end
    end
endmodule
